// File: rtl/bt_rx_fifo_if.sv
`default_nettype none
// ============================================================================
// Module      : bt_rx_fifo_if
// Description : picorv32 native memory bus bundle for the BT receive FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
interface bt_rx_fifo_if;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_valid, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/bt_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : bt_rx_fifo
// Description : HC-05 receive byte FIFO with DATA/STATUS/CTRL registers on the
//               picorv32 bus and a fill-level interrupt. Define
//               BT_RX_TIMEOUT_EN to add the idle-timeout flag.
// Revision    : 1.0 - initial release
// ============================================================================
module bt_rx_fifo #(
    parameter logic [31:0] BASE_ADDR      = 32'h4004_0000,
    parameter int          DEPTH_LOG2     = 4,
    parameter int          IRQ_THRESH     = 8,
    parameter int          TIMEOUT_CYCLES = 5_000_000
) (
    input  wire logic        sysclk,
    input  wire logic        rst,
    input  wire logic [7:0]  rx_data,
    input  wire logic        rx_valid,
    bt_rx_fifo_if.slave      bus,
    output logic             irq
);

    localparam int c_DEPTH = 1 << DEPTH_LOG2;
    localparam int c_CW    = DEPTH_LOG2 + 1;

    logic [7:0]            r_mem [c_DEPTH];
    logic [DEPTH_LOG2-1:0] r_wptr;
    logic [DEPTH_LOG2-1:0] r_rptr;
    logic [c_CW-1:0]       r_count;
    logic                  r_ovf;
    logic                  r_ien;
    logic                  r_ready;
    logic                  r_irq;

    logic w_sel_data, w_sel_stat, w_sel_ctrl, w_hit, w_ack;
    logic w_wr, w_rd, w_pop, w_push, w_drop, w_flush, w_clr;
    logic w_full, w_not_empty, w_ien_next, w_ovf_next, w_to, w_to_next;
    logic [c_CW-1:0] w_count_next;
    logic [31:0]     w_status;
    logic [31:0]     w_rdata;

    assign w_sel_data  = (bus.mem_addr == BASE_ADDR);
    assign w_sel_stat  = (bus.mem_addr == BASE_ADDR + 32'd4);
    assign w_sel_ctrl  = (bus.mem_addr == BASE_ADDR + 32'd8);
    assign w_hit       = bus.mem_valid & (w_sel_data | w_sel_stat | w_sel_ctrl);
    assign w_ack       = r_ready & w_hit;

    assign w_wr        = w_ack & bus.mem_wstrb[0];
    assign w_rd        = w_ack & (bus.mem_wstrb == 4'b0000);

    assign w_full      = (r_count == c_CW'(c_DEPTH));
    assign w_not_empty = (r_count != '0);

    assign w_pop       = w_rd & w_sel_data & w_not_empty;
    assign w_flush     = w_wr & w_sel_ctrl & bus.mem_wdata[1];
    assign w_clr       = w_wr & w_sel_ctrl & bus.mem_wdata[2];
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
    assign w_push      = rx_valid & (~w_full | w_pop) & ~w_flush;
    assign w_drop      = rx_valid & w_full & ~w_pop & ~w_flush;

    assign w_count_next = w_flush ? '0 : (r_count + c_CW'(w_push) - c_CW'(w_pop));
    assign w_ien_next   = (w_wr & w_sel_ctrl) ? bus.mem_wdata[0] : r_ien;
    assign w_ovf_next   = w_clr ? 1'b0 : (r_ovf | w_drop);

`ifdef BT_RX_TIMEOUT_EN
    logic [31:0] r_idle;
    logic        r_to;
    logic        w_to_set;
    logic        w_to_clr;

    assign w_to_set  = (r_idle == 32'(TIMEOUT_CYCLES - 1)) & w_not_empty;
    assign w_to_clr  = w_clr | w_flush | (w_pop & (w_count_next == '0));
    assign w_to_next = w_to_clr ? 1'b0 : (r_to | w_to_set);
    assign w_to      = r_to;

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            r_idle <= '0;
            r_to   <= 1'b0;
        end else begin
            r_to <= w_to_next;
            if (w_push | w_flush | ~w_not_empty)
                r_idle <= '0;
            else
                r_idle <= r_idle + 32'd1;
        end
    end
`else
    assign w_to_next = 1'b0;
    assign w_to      = 1'b0;
`endif

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_ien   <= 1'b0;
            r_ready <= 1'b0;
            r_irq   <= 1'b0;
        end else begin
            r_ready <= w_hit & ~r_ready;
            r_count <= w_count_next;
            r_ovf   <= w_ovf_next;
            r_ien   <= w_ien_next;
            r_irq   <= w_ien_next &
                       ((32'(w_count_next) >= 32'(IRQ_THRESH)) | w_to_next);
            if (w_flush) begin
                r_wptr <= '0;
                r_rptr <= '0;
            end else begin
                if (w_push) r_wptr <= r_wptr + DEPTH_LOG2'(1);
                if (w_pop)  r_rptr <= r_rptr + DEPTH_LOG2'(1);
            end
        end
    end

    always_ff @(posedge sysclk) begin
        if (w_push)
            r_mem[r_wptr] <= rx_data;
    end

    assign w_status = (32'(r_count) << 8) |
                      {28'h0, w_to, r_ovf, w_full, w_not_empty};

    // Read mux reflects pre-edge state, so a flushing cycle still sees the old head.
    always_comb begin
        w_rdata = 32'h0;
        if (r_ready) begin
            if (w_sel_data && w_not_empty)
                w_rdata = {24'h0, r_mem[r_rptr]};
            else if (w_sel_stat)
                w_rdata = w_status;
            else if (w_sel_ctrl)
                w_rdata = {31'h0, r_ien};
        end
    end

    assign bus.mem_ready = r_ready;
    assign bus.mem_rdata = w_rdata;
    assign irq           = r_irq;

    logic w_unused;
    assign w_unused = &{1'b0, bus.mem_wdata[31:3], bus.mem_wstrb[3:1],
                        (TIMEOUT_CYCLES != 0), 1'b0};

endmodule
`default_nettype wire

// File: tb/tb_bt_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_bt_rx_fifo
// Description : Directed scoreboard bench for bt_rx_fifo.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bt_rx_fifo;

    localparam logic [31:0] BASE = 32'h4004_0000;
    localparam logic [31:0] A_DATA = BASE;
    localparam logic [31:0] A_STAT = BASE + 32'd4;
    localparam logic [31:0] A_CTRL = BASE + 32'd8;
`ifdef BT_RX_TIMEOUT_EN
    localparam logic [31:0] SMASK = 32'hFFFF_FFF7;
`else
    localparam logic [31:0] SMASK = 32'hFFFF_FFFF;
`endif

    typedef struct {
        bit          rd;
        logic [31:0] addr;
        logic [31:0] exp;
        logic [31:0] msk;
    } sb_t;

    logic       sysclk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       irq;
    int         errors = 0;
    int         checks = 0;
    sb_t        sbq[$];
    sb_t        mon_e;

    bt_rx_fifo_if bus_if ();

    bt_rx_fifo #(
        .BASE_ADDR      (BASE),
        .DEPTH_LOG2     (4),
        .IRQ_THRESH     (8),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .sysclk   (sysclk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .bus      (bus_if),
        .irq      (irq)
    );

    always #5 sysclk = ~sysclk;

    always @(negedge sysclk) begin
        if (bus_if.mem_ready) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack: got ack with no pending access, required none");
            end else begin
                mon_e = sbq.pop_front();
                if (mon_e.rd) begin
                    checks++;
                    if ((bus_if.mem_rdata & mon_e.msk) !== (mon_e.exp & mon_e.msk)) begin
                        errors++;
                        $display("FAIL rd_%08h: got %08h, required %08h (mask %08h)",
                                 mon_e.addr, bus_if.mem_rdata, mon_e.exp, mon_e.msk);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h, required %08h", name, act, exp);
        end
    endtask

    // Called and returns at posedge+1; optional byte is strobed during the ack cycle.
    task automatic bus(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] ws,
                       input logic [31:0] exp, input logic [31:0] msk,
                       input bit dp, input logic [7:0] pb);
        sb_t e;
        bit  got;
        e.rd = (ws == 4'b0000);
        e.addr = addr;
        e.exp = exp;
        e.msk = msk;
        sbq.push_back(e);
        bus_if.mem_addr  = addr;
        bus_if.mem_wdata = wd;
        bus_if.mem_wstrb = ws;
        bus_if.mem_valid = 1'b1;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge sysclk);
            if (bus_if.mem_ready) got = 1;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout_%08h: got no ack in 20 cycles, required ack", addr);
            void'(sbq.pop_back());
        end else if (dp) begin
            rx_data  = pb;
            rx_valid = 1'b1;
        end
        @(posedge sysclk);
        #1;
        bus_if.mem_valid = 1'b0;
        bus_if.mem_wstrb = 4'b0000;
        rx_valid = 1'b0;
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] exp);
        bus(addr, 32'h0, 4'b0000, exp, 32'hFFFF_FFFF, 0, 8'h00);
    endtask

    task automatic rd_st(input logic [31:0] exp);
        bus(A_STAT, 32'h0, 4'b0000, exp, SMASK, 0, 8'h00);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] wd);
        bus(addr, wd, 4'b1111, 32'h0, 32'h0, 0, 8'h00);
    endtask

    task automatic push(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge sysclk);
        #1;
        rx_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        rx_data = 8'h00;
        rx_valid = 1'b0;
        bus_if.mem_valid = 1'b0;
        bus_if.mem_addr  = 32'h0;
        bus_if.mem_wdata = 32'h0;
        bus_if.mem_wstrb = 4'b0000;
        repeat (3) @(posedge sysclk);
        #1;
        chk("reset_ready", 32'(bus_if.mem_ready), 32'h0);
        chk("reset_rdata", bus_if.mem_rdata, 32'h0);
        chk("reset_irq", 32'(irq), 32'h0);
        @(negedge sysclk);
        rst = 1'b0;
        @(posedge sysclk);
        #1;

        // Basic ordering
        push(8'h41); push(8'h42); push(8'h43);
        rd_st(32'h0000_0301);
        rd(A_DATA, 32'h41);
        rd(A_DATA, 32'h42);
        rd(A_DATA, 32'h43);
        rd(A_DATA, 32'h0);
        rd_st(32'h0000_0000);

        // Overflow: byte 17 dropped
        for (int i = 1; i <= 17; i++) push(8'(i));
        rd_st(32'h0000_1007);
        rd(A_DATA, 32'h01);
        wr(A_CTRL, 32'h4);
        rd_st(32'h0000_0F01);
        wr(A_CTRL, 32'h2);
        rd_st(32'h0000_0000);

        // Full FIFO, push coincident with pop
        for (int i = 1; i <= 16; i++) push(8'(i));
        bus(A_DATA, 32'h0, 4'b0000, 32'h01, 32'hFFFF_FFFF, 1, 8'd17);
        rd_st(32'h0000_1003);
        for (int i = 2; i <= 17; i++) rd(A_DATA, 32'(i));
        rd_st(32'h0000_0000);

        // Threshold interrupt
        wr(A_CTRL, 32'h1);
        rd(A_CTRL, 32'h1);
        for (int i = 0; i < 7; i++) push(8'(8'h60 + i));
        chk("irq_at_7", 32'(irq), 32'h0);
        push(8'h67);
        chk("irq_at_8", 32'(irq), 32'h1);
        rd(A_DATA, 32'h60);
        chk("irq_after_pop", 32'(irq), 32'h0);
        push(8'h68);
        chk("irq_back_8", 32'(irq), 32'h1);
        wr(A_CTRL, 32'h0);
        chk("irq_ien_off", 32'(irq), 32'h0);
        wr(A_CTRL, 32'h2);
        rd_st(32'h0000_0000);

        // Flush wins over a same-cycle push
        push(8'h11); push(8'h22);
        bus(A_CTRL, 32'h2, 4'b0001, 32'h0, 32'h0, 1, 8'h55);
        rd_st(32'h0000_0000);
        rd(A_DATA, 32'h0);

        // Unmapped addresses
        bus_if.mem_wstrb = 4'b0000;
        bus_if.mem_addr  = BASE + 32'hC;
        bus_if.mem_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge sysclk);
            chk("miss_c_ready", 32'(bus_if.mem_ready), 32'h0);
        end
        bus_if.mem_addr = BASE + 32'h2;
        for (int i = 0; i < 4; i++) begin
            @(negedge sysclk);
            chk("miss_2_ready", 32'(bus_if.mem_ready), 32'h0);
        end
        bus_if.mem_valid = 1'b0;
        @(posedge sysclk);
        #1;
        chk("idle_rdata", bus_if.mem_rdata, 32'h0);

        // Async reset during an ack cycle
        wr(A_CTRL, 32'h1);
        for (int i = 0; i < 8; i++) push(8'(8'h70 + i));
        chk("pre_rst_irq", 32'(irq), 32'h1);
        bus_if.mem_addr  = A_STAT;
        bus_if.mem_wstrb = 4'b0000;
        bus_if.mem_valid = 1'b1;
        @(posedge sysclk);
        #1;
        chk("pre_rst_ready", 32'(bus_if.mem_ready), 32'h1);
        rst = 1'b1;
        #1;
        chk("rst_ready", 32'(bus_if.mem_ready), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        @(negedge sysclk);
        rst = 1'b0;
        bus_if.mem_valid = 1'b0;
        @(posedge sysclk);
        #1;
        rd_st(32'h0000_0000);
        rd(A_CTRL, 32'h0);

`ifdef BT_RX_TIMEOUT_EN
        wr(A_CTRL, 32'h1);
        push(8'h77);
        for (int k = 1; k <= 100; k++) begin
            @(posedge sysclk);
            #1;
            if (k == 99) chk("to_irq_99", 32'(irq), 32'h0);
        end
        chk("to_irq_100", 32'(irq), 32'h1);
        bus(A_STAT, 32'h0, 4'b0000, 32'h0000_0109, 32'hFFFF_FFFF, 0, 8'h00);
        rd(A_DATA, 32'h77);
        chk("to_irq_clr", 32'(irq), 32'h0);
        bus(A_STAT, 32'h0, 4'b0000, 32'h0000_0000, 32'hFFFF_FFFF, 0, 8'h00);
`endif

        repeat (3) @(posedge sysclk);
        chk("sb_drained", 32'(sbq.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
